// File: rtl/pwm_pkg.sv
// Shared PWM controller types and helpers.
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } pwm_state_e;

  // Saturate a requested duty to the legal maximum.
  function automatic int unsigned sat_duty(input int unsigned duty, input int unsigned max_duty);
    return (duty > max_duty) ? max_duty : duty;
  endfunction

endpackage

// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty-cycle ramp sequencer: walks the PWM compare value toward a commanded target,
// one step per PWM period, so the core never sees a mid-period compare change.
//
// state | meaning
// IDLE  | cmpa settled at target; commands accepted when en is high
// RAMP  | stepping cmpa toward target on each period_start with en high
module pwm_duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int KPERIOD = 50,
  localparam int DW = $clog2(KPERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          period_start,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_duty,
  input  logic [DW-1:0] cmd_step,
  output logic [DW-1:0] cmpa,
  output logic          busy,
  output logic          done,
  output logic          clamp_err
);

  localparam logic [DW-1:0] KMAX = DW'(KPERIOD);

  pwm_state_e    state_q, state_d;
  logic [DW-1:0] cmpa_q, cmpa_d;
  logic [DW-1:0] target_q, target_d;
  logic [DW-1:0] step_q, step_d;
  logic          done_q, done_d;
  logic          clamp_q, clamp_d;

  logic          accept;
  logic [DW-1:0] cmd_target;
  logic          ramp_up;
  logic [DW:0]   diff;

  assign cmd_ready  = (state_q == IDLE) && en && !rst;
  assign accept     = cmd_valid && cmd_ready;
  assign cmd_target = DW'(sat_duty(32'(cmd_duty), 32'(KPERIOD)));

  // Distance is taken in DW+1 bits so the direction-dependent subtract never wraps.
  assign ramp_up = target_q > cmpa_q;
  assign diff    = ramp_up ? ({1'b0, target_q} - {1'b0, cmpa_q})
                           : ({1'b0, cmpa_q} - {1'b0, target_q});

  always_comb begin
    state_d  = state_q;
    cmpa_d   = cmpa_q;
    target_d = target_q;
    step_d   = step_q;
    done_d   = 1'b0;
    clamp_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = cmd_target;
          step_d   = (cmd_step == '0) ? DW'(1) : cmd_step;
          clamp_d  = cmd_duty > KMAX;
          if (cmd_target == cmpa_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
          end
        end
      end
      RAMP: begin
        if (period_start && en) begin
          if (diff <= {1'b0, step_q}) begin
            cmpa_d  = target_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (ramp_up) begin
            cmpa_d = cmpa_q + step_q;
          end else begin
            cmpa_d = cmpa_q - step_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cmpa_q   <= '0;
      target_q <= '0;
      step_q   <= '0;
      done_q   <= 1'b0;
      clamp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmpa_q   <= cmpa_d;
      target_q <= target_d;
      step_q   <= step_d;
      done_q   <= done_d;
      clamp_q  <= clamp_d;
    end
  end

  assign cmpa      = cmpa_q;
  assign busy      = (state_q == RAMP);
  assign done      = done_q;
  assign clamp_err = clamp_q;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Self-checking bench for pwm_duty_ramp_ctrl: vector table plus directed multi-cycle sequences.
module tb_pwm_duty_ramp_ctrl;

  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          period_start = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_duty = '0;
  logic [DW-1:0] cmd_step = '0;
  logic [DW-1:0] cmpa;
  logic          busy, done, clamp_err;

  int n_checks = 0;
  int n_fail = 0;

  pwm_duty_ramp_ctrl #(.KPERIOD(50)) dut (
    .clk(clk), .rst(rst), .en(en), .period_start(period_start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_duty(cmd_duty),
    .cmd_step(cmd_step), .cmpa(cmpa), .busy(busy), .done(done),
    .clamp_err(clamp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic          ps;
    logic          valid;
    logic [DW-1:0] duty;
    logic [DW-1:0] step;
    logic          ready;
    logic [DW-1:0] cmpa;
    logic          busy;
    logic          done;
    logic          clamp;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic e, input logic p, input logic v, input int d, input int s,
                              input logic r, input int c, input logic b, input logic dn, input logic cl);
    vec_t t;
    t.en = e; t.ps = p; t.valid = v; t.duty = DW'(d); t.step = DW'(s);
    t.ready = r; t.cmpa = DW'(c); t.busy = b; t.done = dn; t.clamp = cl;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input int c, input int b, input int dn, input int cl);
    chk({nm, " cmpa"}, int'(cmpa), c);
    chk({nm, " busy"}, int'(busy), b);
    chk({nm, " done"}, int'(done), dn);
    chk({nm, " clamp_err"}, int'(clamp_err), cl);
  endtask

  // 15 quiet cycles then a strobe; outputs are observed right after the strobe edge.
  task automatic period();
    repeat (15) step_clk();
    period_start = 1'b1;
    step_clk();
    period_start = 1'b0;
  endtask

  task automatic send(input int d, input int s, input logic ps);
    cmd_valid = 1'b1;
    cmd_duty = DW'(d);
    cmd_step = DW'(s);
    period_start = ps;
    step_clk();
    cmd_valid = 1'b0;
    period_start = 1'b0;
  endtask

  initial begin
    // Reset: two cycles with rst high
    step_clk();
    chk("ready during rst", int'(cmd_ready), 0);
    step_clk();
    chk_out("after rst", 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("ready after rst", int'(cmd_ready), 1);

    // Table: fast up-ramp 0->20 step 5, busy-time command ignored, equal-target, clamp, en gating
    vecs[0]  = mk(1, 0, 0,  0,  0, 1,  0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 1, 20,  5, 1,  0, 1, 0, 0);
    vecs[2]  = mk(1, 0, 0,  0,  0, 0,  0, 1, 0, 0);
    vecs[3]  = mk(1, 1, 0,  0,  0, 0,  5, 1, 0, 0);
    vecs[4]  = mk(1, 1, 1, 40,  1, 0, 10, 1, 0, 0);
    vecs[5]  = mk(1, 0, 0,  0,  0, 0, 10, 1, 0, 0);
    vecs[6]  = mk(1, 1, 0,  0,  0, 0, 15, 1, 0, 0);
    vecs[7]  = mk(1, 1, 0,  0,  0, 0, 20, 0, 1, 0);
    vecs[8]  = mk(1, 0, 0,  0,  0, 1, 20, 0, 0, 0);
    vecs[9]  = mk(1, 0, 1, 20,  3, 1, 20, 0, 1, 0);
    vecs[10] = mk(1, 0, 1, 63, 20, 1, 20, 1, 0, 1);
    vecs[11] = mk(1, 0, 0,  0,  0, 0, 20, 1, 0, 0);
    vecs[12] = mk(1, 1, 0,  0,  0, 0, 40, 1, 0, 0);
    vecs[13] = mk(1, 1, 0,  0,  0, 0, 50, 0, 1, 0);
    vecs[14] = mk(1, 0, 0,  0,  0, 1, 50, 0, 0, 0);
    vecs[15] = mk(0, 0, 1, 10,  1, 0, 50, 0, 0, 0);
    vecs[16] = mk(1, 0, 0,  0,  0, 1, 50, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      en = vecs[i].en;
      period_start = vecs[i].ps;
      cmd_valid = vecs[i].valid;
      cmd_duty = vecs[i].duty;
      cmd_step = vecs[i].step;
      #1;
      chk($sformatf("vec%0d ready", i), int'(cmd_ready), int'(vecs[i].ready));
      step_clk();
      chk_out($sformatf("vec%0d", i), int'(vecs[i].cmpa), int'(vecs[i].busy),
              int'(vecs[i].done), int'(vecs[i].clamp));
    end
    period_start = 1'b0;
    cmd_valid = 1'b0;

    // Reset mid-ramp: 50 -> 0 step 5, one step then rst
    send(0, 5, 1'b0);
    chk("rstmid busy", int'(busy), 1);
    period();
    chk("rstmid first step", int'(cmpa), 45);
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    chk_out("rstmid after rst", 0, 0, 0, 0);
    #1;
    chk("rstmid ready", int'(cmd_ready), 1);

    // Freeze/resume on 0->20 step 5 with 16-clk periods
    send(20, 5, 1'b0);
    period();
    chk("frz s1", int'(cmpa), 5);
    period();
    chk("frz s2", int'(cmpa), 10);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      period();
      chk($sformatf("frz hold%0d cmpa", k), int'(cmpa), 10);
      chk($sformatf("frz hold%0d busy", k), int'(busy), 1);
    end
    en = 1'b1;
    period();
    chk_out("frz resume s3", 15, 1, 0, 0);
    period();
    chk_out("frz resume s4", 20, 0, 1, 0);
    step_clk();
    chk("frz done single", int'(done), 0);

    // Down-ramp with remainder: 20 -> 3 step 7
    send(3, 7, 1'b0);
    period();
    chk_out("down s1", 13, 1, 0, 0);
    period();
    chk_out("down s2", 6, 1, 0, 0);
    period();
    chk_out("down s3", 3, 0, 1, 0);

    // Step 0 behaves as step 1: 3 -> 5
    send(5, 0, 1'b0);
    period();
    chk_out("step0 s1", 4, 1, 0, 0);
    period();
    chk_out("step0 s2", 5, 0, 1, 0);

    // Accept coincident with period_start: no step on the accept cycle
    send(8, 3, 1'b1);
    chk_out("coinc accept", 5, 1, 0, 0);
    period();
    chk_out("coinc s1", 8, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
